// File: rtl/axi_lite_master_ctrl_if.sv
// rtl/axi_lite_master_ctrl_if.sv - AXI-Lite channel bundle with master and slave views
interface axi_lite_ifc #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_master_ctrl.sv
// rtl/axi_lite_master_ctrl.sv - single-outstanding AXI-Lite master driven by a cmd/rsp handshake
module axi_lite_master_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic [CNT_W-1:0]    rsp_cycles,
  axi_lite_ifc.master         m_axi_lite
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t state, next_state;
  logic   run;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d, rsp_valid_d;
  logic accept, aw_hs, w_hs, ar_hs, b_hs, r_hs, cnt_active;
  logic [CNT_W-1:0] cnt;

  // run holds cmd_ready low on the reset edge itself, not just after it
  assign cmd_ready  = run && (state == IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign aw_hs      = awvalid_q && m_axi_lite.awready;
  assign w_hs       = wvalid_q && m_axi_lite.wready;
  assign ar_hs      = arvalid_q && m_axi_lite.arready;
  assign b_hs       = bready_q && m_axi_lite.bvalid;
  assign r_hs       = rready_q && m_axi_lite.rvalid;
  assign cnt_active = state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};

  assign m_axi_lite.awaddr  = addr_q;
  assign m_axi_lite.awprot  = 3'b000;
  assign m_axi_lite.awvalid = awvalid_q;
  assign m_axi_lite.wdata   = wdata_q;
  assign m_axi_lite.wstrb   = wstrb_q;
  assign m_axi_lite.wvalid  = wvalid_q;
  assign m_axi_lite.bready  = bready_q;
  assign m_axi_lite.araddr  = addr_q;
  assign m_axi_lite.arprot  = 3'b000;
  assign m_axi_lite.arvalid = arvalid_q;
  assign m_axi_lite.rready  = rready_q;
  assign rsp_cycles         = cnt;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state     <= IDLE;
      run       <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= next_state;
      run       <= 1'b1;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      rsp_valid <= rsp_valid_d;
    end
  end

  // a write channel counts as done once its valid has dropped or is handshaking now
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) next_state = WR_RESP;
      WR_RESP: if (b_hs) next_state = RSP;
      RD_REQ:  if (ar_hs) next_state = RD_RESP;
      RD_RESP: if (r_hs) next_state = RSP;
      RSP:     if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    awvalid_d   = awvalid_q && !aw_hs;
    wvalid_d    = wvalid_q && !w_hs;
    arvalid_d   = arvalid_q && !ar_hs;
    if (accept) begin
      awvalid_d = cmd_write;
      wvalid_d  = cmd_write;
      arvalid_d = !cmd_write;
    end
    bready_d    = (next_state == WR_RESP);
    rready_d    = (next_state == RD_RESP);
    rsp_valid_d = (next_state == RSP);
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      cnt       <= '0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        cnt     <= '0;
      end else if (cnt_active && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
      if (b_hs) begin
        rsp_write <= 1'b1;
        rsp_rdata <= '0;
        rsp_resp  <= m_axi_lite.bresp;
      end else if (r_hs) begin
        rsp_write <= 1'b0;
        rsp_rdata <= m_axi_lite.rdata;
        rsp_resp  <= m_axi_lite.rresp;
      end
    end
  end

endmodule

// File: doc/axi_lite_master_ctrl.md
# axi_lite_master_ctrl

Single-outstanding AXI-Lite master that converts a simple command/response handshake into AXI-Lite write and read transactions on an `axi_lite_ifc.master` port. It is the initiator counterpart to the AXI-Lite slaves in the design: the block RAM wrapper in the bench, and the AXI-Lite side of the APB converter. Benches and sequencers use it to issue register accesses and to measure per-transaction slave latency.

## Interface
- `ADDR_W`, 32: address width; must equal the `axi_lite_ifc` address width.
- `DATA_W`, 32: data width, 32 or 64; `wstrb` width is `DATA_W/8`.
- `CNT_W`, 16: width of the latency counter.
- `clk`  in  1  single clock; all logic on rising edge.
- `aresetn`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  byte address.
- `cmd_wdata`  in  DATA_W  write data; ignored for reads.
- `cmd_wstrb`  in  DATA_W/8  byte strobes; ignored for reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_write`  out  1  response belongs to a write.
- `rsp_rdata`  out  DATA_W  read data; 0 for writes.
- `rsp_resp`  out  2  `bresp` or `rresp` as returned.
- `rsp_cycles`  out  CNT_W  cycles from first AXI valid to response handshake, saturating.
- `m_axi_lite`  master  `axi_lite_ifc.master`  aw/w/b/ar/r channels.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: `cmd_ready`=1. On `cmd_valid`, capture addr/data/strb/write, clear the counter, and go to WR_REQ (write) or RD_REQ (read).
- WR_REQ: `awvalid` and `wvalid` go high together. Each drops independently on the cycle after its own handshake (`awvalid&awready`, `wvalid&wready`). Handshakes may occur in either order or in the same cycle. Go to WR_RESP once both channels have completed.
- WR_RESP: `bready`=1. On `bvalid`, latch `bresp` into `rsp_resp`, set `rsp_write`=1 and `rsp_rdata`=0, then go to RSP.
- RD_REQ: `arvalid`=1 until `arready`, then go to RD_RESP.
- RD_RESP: `rready`=1. On `rvalid`, latch `rdata` and `rresp`, set `rsp_write`=0, then go to RSP.
- RSP: `rsp_valid`=1, with all rsp fields held stable. On `rsp_ready`, go to IDLE.
- Valid/data stability: once asserted, `awvalid`/`wvalid`/`arvalid` and their payloads must not change until the matching ready. They are never withdrawn except by reset.
- `awprot`/`arprot` are tied to 0 if present on the interface.
- `bready`/`rready` are 0 in every state other than WR_RESP/RD_RESP.
- Counter: counts every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP. The response-handshake cycle is included in the count. It saturates at 2^CNT_W-1 and is frozen in RSP.
- Non-OKAY responses (SLVERR, DECERR) are passed through unchanged. There is no retry.
- Reset: while `aresetn`=0 at a clock edge, the FSM goes to IDLE. At that edge `cmd_ready`, `rsp_valid`, all AXI valids and readies, `rsp_write`, `rsp_rdata`, `rsp_resp` and `rsp_cycles` are cleared to 0. Reset in the middle of a transaction abandons it; the slave is reset by the same `aresetn`. `cmd_ready` reads 1 on the first cycle after reset is released.

## Timing
- All outputs are registered, except `cmd_ready`, which is decoded from the state register.
- If `cmd_valid` is accepted at edge N, the AXI valids are high in cycle N+1.
- Minimum write transaction, with the slave having ready/valid high immediately:
  - aw/w handshake in cycle N+1;
  - WR_RESP in N+2, `bvalid` seen;
  - `rsp_valid` in N+3, with `rsp_cycles`=2;
  - IDLE in N+4 if `rsp_ready` is held high.
- The minimum read follows the same pattern: `rsp_valid` in N+3.
- Throughput: at most one transaction per 4 cycles. There is exactly one transaction outstanding at any time.
- Back-pressure on `rsp_ready` stalls the block indefinitely in RSP. No new command is accepted until the response is consumed.

## Test plan
- Write, then read back: write addr 0x10, data 0xDEADBEEF, strb 0xF; then read 0x10 → write response `rsp_resp`=0; read response `rsp_rdata`=0xDEADBEEF, `rsp_resp`=0; `rsp_valid` 3 cycles after each command accept.
- Split aw/w: slave asserts `awready` 3 cycles before `wready` → `awvalid` drops first, `wvalid` stays high with stable `wdata` until its handshake; exactly one `bready` handshake occurs.
- Partial strobe: write 0xAABBCCDD with strb 0x5 over a location holding 0x11223344, then read back → `rsp_rdata`=0x11BB33DD.
- Stalls: slave delays `arready` by 5 cycles and `rvalid` by 4 cycles; bench holds `rsp_ready` low for 6 cycles → `rsp_cycles`=11; all rsp fields stable during the stall; `cmd_ready`=0 until the response handshake.
- Error passthrough: slave returns `bresp`=2'b10 → `rsp_resp`=2'b10, `rsp_write`=1; the next command is accepted normally.
- Reset in WR_REQ, with `awvalid` high and the slave not ready → the cycle after the reset edge, all valids are 0, `cmd_ready`=0 and `rsp_cycles`=0; after release, `cmd_ready`=1 and a fresh read completes correctly.
